piso_frame_tx: RTL



---
 rtl/piso_frame_tx.sv | 102 ++++++++++
 1 files changed

// File: rtl/piso_frame_tx.sv
// Framed parallel-in/serial-out transmitter.
// Frame on SO: start(1), N data bits, optional even parity, stop(0); idle level 0.
// SO is registered: each edge loads the bit that belongs to the state being entered.
module piso_frame_tx #(
  parameter int N         = 5,
  parameter int MSB_FIRST = 0,
  parameter int PARITY_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         SO,
  output logic         frame_active,
  output logic         done
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   sh, sh_nxt, sh_shift;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           par, par_nxt;
  logic           so_nxt;
  logic           bit_out;
  logic           accept;

  // Ready only where a new word can start without a gap; held low during reset
  assign load_ready   = !reset && (state == IDLE || state == STOP);
  assign accept       = load_valid && load_ready;
  assign frame_active = (state != IDLE);
  assign done         = (state == STOP);

  // Exit bit and shift direction follow the bit order
  assign bit_out  = (MSB_FIRST != 0) ? sh[N-1] : sh[0];
  assign sh_shift = (MSB_FIRST != 0) ? {sh[N-2:0], 1'b0} : {1'b0, sh[N-1:1]};

  // Next state, next SO bit and datapath updates
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    par_nxt   = par;
    so_nxt    = 1'b0;
    case (state)
      IDLE, STOP: begin
        if (accept) begin
          state_nxt = START;
          sh_nxt    = din;
          par_nxt   = ^din;
          so_nxt    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        state_nxt = DATA;
        so_nxt    = bit_out;
        sh_nxt    = sh_shift;
        cnt_nxt   = '0;
      end
      DATA: begin
        if (cnt == CW'(N-1)) begin
          cnt_nxt = '0;
          if (PARITY_EN != 0) begin
            state_nxt = PARITY;
            so_nxt    = par;
          end else begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
          so_nxt  = bit_out;
          sh_nxt  = sh_shift;
        end
      end
      PARITY: state_nxt = STOP;
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset abandons any frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      SO    <= 1'b0;
      sh    <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_nxt;
      SO    <= so_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
      par   <= par_nxt;
    end
  end

endmodule
